// File: rtl/if_stage.sv
// Instruction fetch stage: holds the fetch PC, issues one-outstanding imem requests,
// and feeds {pc, inst, valid} to ID through a 1-entry skid, squashing wrong-path fetches.
package core;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  localparam if_id_t if_id_rst = '0;
endpackage

// state  | meaning
// S_IDLE | no request outstanding, waiting for en
// S_REQ  | request at pc outstanding
// S_SKID | fetched word parked in skid while ID stalls
// S_DROP | wrong-path request outstanding, response will be discarded
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         next_rdy,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output core::if_id_t if_id,
  output logic         rdy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SKID, S_DROP} state_t;

  state_t       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_inst_q, skid_inst_d;
  core::if_id_t if_id_q, if_id_d;
  logic         free;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign free      = !if_id_q.valid || next_rdy;
  assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  // pc already points at the redirect target while a dropped request drains
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign if_id     = if_id_q;
  assign rdy       = en && next_rdy;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_id_d     = if_id_q;
    if (next_rdy) if_id_d.valid = 1'b0;

    if (redirect_valid) begin
      pc_d          = {redirect_pc[31:2], 2'b00};
      if_id_d.valid = 1'b0;
      skid_pc_d     = '0;
      skid_inst_d   = '0;
      case (state_q)
        S_REQ: begin
          if (imem_ack) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end
        S_DROP:  state_d = imem_ack ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: if (en) state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            pc_d = pc_q + 32'd4;
            if (free) begin
              if_id_d = '{pc: pc_q, inst: imem_rdata, valid: 1'b1};
              state_d = en ? S_REQ : S_IDLE;
            end else begin
              skid_pc_d   = pc_q;
              skid_inst_d = imem_rdata;
              state_d     = S_SKID;
            end
          end
        end
        S_SKID: begin
          if (next_rdy) begin
            if_id_d = '{pc: skid_pc_q, inst: skid_inst_q, valid: 1'b1};
            state_d = en ? S_REQ : S_IDLE;
          end
        end
        S_DROP: if (imem_ack) state_d = en ? S_REQ : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      if_id_q     <= core::if_id_rst;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_id_q     <= if_id_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, ID stall/skid, redirects, en gating,
// and PC wrap plus mid-request reset on a second instance with RESET_PC=0xFFFF_FFFC.
module tb_if_stage;
  logic         clk = 1'b0;
  logic         rst1, rst2, en, next_rdy, redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req1, imem_req2, imem_ack1, imem_ack2;
  logic [31:0]  imem_addr1, imem_addr2, imem_rdata1, imem_rdata2;
  core::if_id_t id1, id2;
  logic         rdy1, rdy2;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst1), .en(en), .next_rdy(next_rdy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(imem_ack1),
    .imem_rdata(imem_rdata1), .if_id(id1), .rdy(rdy1));

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .en(en), .next_rdy(next_rdy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
    .imem_rdata(imem_rdata2), .if_id(id2), .rdy(rdy2));

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: applies acks/data for the upcoming posedge, then returns at the next negedge.
  task automatic tick(input logic a1, input logic a2);
    imem_ack1   = a1;
    imem_ack2   = a2;
    imem_rdata1 = inst_of(imem_addr1);
    imem_rdata2 = inst_of(imem_addr2);
    @(posedge clk);
    @(negedge clk);
    imem_ack1      = 1'b0;
    imem_ack2      = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; en = 1'b0; next_rdy = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack1 = 1'b0; imem_ack2 = 1'b0; imem_rdata1 = '0; imem_rdata2 = '0;
    @(negedge clk);
    tick(0, 0);
    tick(0, 0);
    chk("rst_req", {31'b0, imem_req1}, 32'd0);
    chk("rst_valid", {31'b0, id1.valid}, 32'd0);
    chk("rst_addr", imem_addr1, 32'h0);

    // sequential fetch, zero-wait memory
    rst1 = 1'b0; en = 1'b1;
    tick(0, 0);
    chk("issue_req", {31'b0, imem_req1}, 32'd1);
    chk("issue_addr", imem_addr1, 32'h0);
    chk("issue_valid", {31'b0, id1.valid}, 32'd0);
    chk("rdy", {31'b0, rdy1}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick(1, 0);
      chk("seq_addr", imem_addr1, 32'(4 * (k + 1)));
      chk("seq_pc", id1.pc, 32'(4 * k));
      chk("seq_inst", id1.inst, inst_of(32'(4 * k)));
      chk("seq_valid", {31'b0, id1.valid}, 32'd1);
    end

    // ID stall: 0xC goes to the skid
    next_rdy = 1'b0;
    tick(1, 0);
    chk("stall_req", {31'b0, imem_req1}, 32'd0);
    chk("stall_pc", id1.pc, 32'h8);
    chk("rdy_stall", {31'b0, rdy1}, 32'd0);
    tick(0, 0);
    tick(0, 0);
    chk("stall3_req", {31'b0, imem_req1}, 32'd0);
    chk("stall3_pc", id1.pc, 32'h8);
    chk("stall3_valid", {31'b0, id1.valid}, 32'd1);
    next_rdy = 1'b1;
    tick(0, 0);
    chk("skid_pc", id1.pc, 32'hC);
    chk("skid_inst", id1.inst, inst_of(32'hC));
    chk("resume_req", {31'b0, imem_req1}, 32'd1);
    chk("resume_addr", imem_addr1, 32'h10);
    for (int k = 0; k < 4; k++) begin
      tick(1, 0);
      chk("seq2_pc", id1.pc, 32'(32'h10 + 4 * k));
      chk("seq2_addr", imem_addr1, 32'(32'h14 + 4 * k));
    end

    // redirect to 0x100 while 0x20 is outstanding and unacked
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(0, 0);
    chk("drop_req", {31'b0, imem_req1}, 32'd1);
    chk("drop_addr", imem_addr1, 32'h20);
    chk("drop_valid", {31'b0, id1.valid}, 32'd0);
    tick(0, 0);
    chk("drop2_addr", imem_addr1, 32'h20);
    chk("drop2_valid", {31'b0, id1.valid}, 32'd0);
    tick(1, 0);
    chk("drop_ack_valid", {31'b0, id1.valid}, 32'd0);
    chk("tgt_req", {31'b0, imem_req1}, 32'd1);
    chk("tgt_addr", imem_addr1, 32'h100);
    tick(1, 0);
    chk("tgt_pc", id1.pc, 32'h100);
    chk("tgt_inst", id1.inst, inst_of(32'h100));
    chk("tgt_valid", {31'b0, id1.valid}, 32'd1);

    // redirect to 0x203 with same-cycle ack and valid if_id
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick(1, 0);
    chk("redir2_valid", {31'b0, id1.valid}, 32'd0);
    chk("redir2_req", {31'b0, imem_req1}, 32'd0);
    tick(0, 0);
    chk("redir2_addr", imem_addr1, 32'h200);
    chk("redir2_req1", {31'b0, imem_req1}, 32'd1);
    tick(1, 0);
    chk("redir2_pc", id1.pc, 32'h200);
    chk("redir2_pcv", {31'b0, id1.valid}, 32'd1);

    // en dropped with 0x204 outstanding
    en = 1'b0;
    tick(0, 0);
    chk("en0_req_held", {31'b0, imem_req1}, 32'd1);
    chk("en0_addr", imem_addr1, 32'h204);
    tick(1, 0);
    chk("en0_done_pc", id1.pc, 32'h204);
    chk("en0_done_valid", {31'b0, id1.valid}, 32'd1);
    chk("en0_noreq", {31'b0, imem_req1}, 32'd0);
    tick(0, 0);
    tick(0, 0);
    chk("en0_idle_req", {31'b0, imem_req1}, 32'd0);
    chk("en0_consumed", {31'b0, id1.valid}, 32'd0);
    en = 1'b1;
    tick(0, 0);
    chk("en1_req", {31'b0, imem_req1}, 32'd1);
    chk("en1_addr", imem_addr1, 32'h208);

    // second instance: PC wrap and mid-request reset
    rst1 = 1'b1;
    tick(0, 0);
    chk("r2_rst_req", {31'b0, imem_req2}, 32'd0);
    chk("r2_rst_addr", imem_addr2, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    tick(0, 0);
    chk("r2_issue_addr", imem_addr2, 32'hFFFF_FFFC);
    chk("r2_issue_req", {31'b0, imem_req2}, 32'd1);
    tick(0, 1);
    chk("wrap_pc", id2.pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr2, 32'h0);
    tick(0, 1);
    chk("wrap2_pc", id2.pc, 32'h0);
    chk("wrap2_addr", imem_addr2, 32'h4);
    rst2 = 1'b1;
    tick(0, 1);
    chk("midrst_req", {31'b0, imem_req2}, 32'd0);
    chk("midrst_valid", {31'b0, id2.valid}, 32'd0);
    chk("midrst_addr", imem_addr2, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    tick(0, 0);
    chk("restart_req", {31'b0, imem_req2}, 32'd1);
    chk("restart_addr", imem_addr2, 32'hFFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
